// File: rtl/control_unit.sv
// control_unit: instruction sequencer for the 4-bit CPU.
// Runs the fixed 8-phase machine cycle (A1 A2 A3 M1 M2 X1 X2 X3) on the
// multiplexed 4-bit bus. It drives the 12-bit PC out as three nibbles,
// fetches the 8-bit instruction in two nibbles (OPR in M1, OPA in M2) and
// issues one-clock datapath strobes in X1.
// Bus protocol: there is no valid/ready handshake. The bus is strictly
// time-slotted by phase: the sequencer drives the bus (data_oe=1) in A1..A3
// and samples data_in on the closing edge of M1 and M2. Nothing stalls.
module control_unit (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] data_in,
  output logic [3:0] data_out,
  output logic       data_oe,
  output logic       sync,
  output logic       clear_carry,
  output logic       clear_accumulator,
  output logic       write_accumulator,
  output logic [1:0] acc_input_sel,
  output logic       write_register,
  output logic       reg_input_sel,
  output logic [3:0] inst_operand,
  output logic       illegal_op
);

  typedef enum logic [2:0] {
    PH_A1 = 3'd0,
    PH_A2 = 3'd1,
    PH_A3 = 3'd2,
    PH_M1 = 3'd3,
    PH_M2 = 3'd4,
    PH_X1 = 3'd5,
    PH_X2 = 3'd6,
    PH_X3 = 3'd7
  } phase_t;

  localparam logic [1:0] ACC_IN_FROM_REG = 2'd0;
  localparam logic [1:0] ACC_IN_FROM_ALU = 2'd1;
  localparam logic [1:0] ACC_IN_FROM_IMM = 2'd2;
  localparam logic       REG_IN_FROM_ACC = 1'b0;

  phase_t      phase_q;
  phase_t      phase_d;
  logic [11:0] pc_q;
  logic [3:0]  opr_q;
  logic [3:0]  opa_q;

  // Phase register: reset parks the machine at A1.
  always_ff @(posedge clock) begin
    if (reset) begin
      phase_q <= PH_A1;
    end else begin
      phase_q <= phase_d;
    end
  end

  // Next phase: fixed ring, one step per clock, no stalls.
  always_comb begin
    phase_d = PH_A1;
    case (phase_q)
      PH_A1:   phase_d = PH_A2;
      PH_A2:   phase_d = PH_A3;
      PH_A3:   phase_d = PH_M1;
      PH_M1:   phase_d = PH_M2;
      PH_M2:   phase_d = PH_X1;
      PH_X1:   phase_d = PH_X2;
      PH_X2:   phase_d = PH_X3;
      PH_X3:   phase_d = PH_A1;
      default: phase_d = PH_A1;
    endcase
  end

  // Program counter and instruction latches; PC steps on the X3->A1 edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q  <= 12'h000;
      opr_q <= 4'h0;
      opa_q <= 4'h0;
    end else begin
      if (phase_q == PH_X3) begin
        pc_q <= pc_q + 12'h001;
      end
      if (phase_q == PH_M1) begin
        opr_q <= data_in;
      end
      if (phase_q == PH_M2) begin
        opa_q <= data_in;
      end
    end
  end

  // Outputs: address nibbles, sync, and X1 decode. While reset is high the
  // outputs present A1 of address 0 and nothing else, so an instruction cut
  // short by reset never reaches its X1 strobes.
  always_comb begin
    data_out          = 4'h0;
    data_oe           = 1'b0;
    sync              = 1'b0;
    clear_carry       = 1'b0;
    clear_accumulator = 1'b0;
    write_accumulator = 1'b0;
    acc_input_sel     = ACC_IN_FROM_REG;
    write_register    = 1'b0;
    illegal_op        = 1'b0;
    if (reset) begin
      data_oe = 1'b1;
    end else begin
      case (phase_q)
        PH_A1: begin
          data_oe  = 1'b1;
          data_out = pc_q[3:0];
        end
        PH_A2: begin
          data_oe  = 1'b1;
          data_out = pc_q[7:4];
        end
        PH_A3: begin
          data_oe  = 1'b1;
          data_out = pc_q[11:8];
        end
        PH_X3: begin
          sync = 1'b1;
        end
        PH_X1: begin
          case (opr_q)
            4'h0: begin
              // Only 0x00 is NOP; 0x01..0x0F are undecoded.
              if (opa_q != 4'h0) begin
                illegal_op = 1'b1;
              end
            end
            4'hD: begin
              write_accumulator = 1'b1;
              acc_input_sel     = ACC_IN_FROM_IMM;
            end
            4'hA: begin
              write_accumulator = 1'b1;
              acc_input_sel     = ACC_IN_FROM_REG;
            end
            4'hB: begin
              // Exchange: datapath swaps acc and Rn on the same edge.
              write_accumulator = 1'b1;
              acc_input_sel     = ACC_IN_FROM_REG;
              write_register    = 1'b1;
            end
            4'h8: begin
              write_accumulator = 1'b1;
              acc_input_sel     = ACC_IN_FROM_ALU;
            end
            4'hF: begin
              if (opa_q == 4'h0) begin
                clear_accumulator = 1'b1;
                clear_carry       = 1'b1;
              end else if (opa_q == 4'h1) begin
                clear_carry = 1'b1;
              end else begin
                illegal_op = 1'b1;
              end
            end
            default: begin
              illegal_op = 1'b1;
            end
          endcase
        end
        default: begin
        end
      endcase
    end
  end

  assign reg_input_sel = REG_IN_FROM_ACC;
  assign inst_operand  = reset ? 4'h0 : opa_q;

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed, table-driven bench for control_unit with a
// small accumulator/register datapath model driven by the DUT strobes.
module tb_control_unit;

  // ---------------- clock / reset ----------------
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] data_in = 4'h0;

  always #5 clock = ~clock;

  logic [3:0] data_out;
  logic       data_oe;
  logic       sync;
  logic       clear_carry;
  logic       clear_accumulator;
  logic       write_accumulator;
  logic [1:0] acc_input_sel;
  logic       write_register;
  logic       reg_input_sel;
  logic [3:0] inst_operand;
  logic       illegal_op;

  control_unit dut (
    .clock             (clock),
    .reset             (reset),
    .data_in           (data_in),
    .data_out          (data_out),
    .data_oe           (data_oe),
    .sync              (sync),
    .clear_carry       (clear_carry),
    .clear_accumulator (clear_accumulator),
    .write_accumulator (write_accumulator),
    .acc_input_sel     (acc_input_sel),
    .write_register    (write_register),
    .reg_input_sel     (reg_input_sel),
    .inst_operand      (inst_operand),
    .illegal_op        (illegal_op)
  );

  // Packed view of all outputs:
  // {data_out, data_oe, sync, cc, ca, wa, sel[1:0], wr, rsel, operand, ill}
  logic [17:0] act;
  assign act = {data_out, data_oe, sync, clear_carry, clear_accumulator,
                write_accumulator, acc_input_sel, write_register,
                reg_input_sel, inst_operand, illegal_op};

  localparam logic [17:0] RESET_VIEW = {4'h0, 1'b1, 1'b0, 6'b0, 1'b0, 4'h0, 1'b0};

  // ---------------- datapath model ----------------
  logic       model_clr = 1'b1;
  logic [3:0] m_acc;
  logic [3:0] m_reg [16];

  // Accumulator/register file behaviour as seen by the sequencer's strobes.
  always @(posedge clock) begin
    if (model_clr) begin
      m_acc <= 4'h0;
      for (int r = 0; r < 16; r++) m_reg[r] <= 4'h0;
    end else begin
      if (write_register) m_reg[inst_operand] <= m_acc;
      if (clear_accumulator) begin
        m_acc <= 4'h0;
      end else if (write_accumulator) begin
        case (acc_input_sel)
          2'd0:    m_acc <= m_reg[inst_operand];
          2'd1:    m_acc <= m_acc + m_reg[inst_operand];
          default: m_acc <= inst_operand;
        endcase
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [7:0] inst;
    logic       cc;
    logic       ca;
    logic       wa;
    logic [1:0] sel;
    logic       wr;
    logic       ill;
  } vec_t;

  logic [17:0] exp_q[$];
  int          tests = 0;
  int          fails = 0;
  logic [11:0] exp_pc = 12'h000;
  logic [3:0]  prev_opa = 4'h0;

  task automatic check(input string name, input logic [17:0] got, input logic [17:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%05h exp=%05h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] inst, input logic cc, input logic ca,
                              input logic wa, input logic [1:0] sel, input logic wr,
                              input logic ill);
    vec_t v;
    v.inst = inst; v.cc = cc; v.ca = ca; v.wa = wa; v.sel = sel; v.wr = wr; v.ill = ill;
    return v;
  endfunction

  function automatic logic [17:0] exp_pack(input int k, input logic [11:0] pc,
                                           input logic [3:0] operand, input vec_t v);
    logic [3:0] dout;
    logic       oe;
    logic       sy;
    dout = 4'h0;
    oe   = 1'b0;
    if (k < 3) begin
      oe   = 1'b1;
      dout = pc[k*4 +: 4];
    end
    sy = (k == 7);
    if (k == 5) return {dout, oe, sy, v.cc, v.ca, v.wa, v.sel, v.wr, 1'b0, operand, v.ill};
    return {dout, oe, sy, 6'b0, 1'b0, operand, 1'b0};
  endfunction

  // ---------------- driver ----------------
  // Entered at the negedge inside A1; leaves at the negedge of the next A1.
  // abort_at >= 0 raises reset in that phase and ends the cycle there.
  task automatic run_cycle(input vec_t v, input int abort_at);
    for (int k = 0; k < 8; k++) begin
      data_in = (k == 3) ? v.inst[7:4] : (k == 4) ? v.inst[3:0] : 4'h0;
      if (k == abort_at) begin
        reset = 1'b1;
        #1;
        exp_q.push_back(RESET_VIEW);
        check($sformatf("abort k=%0d", k), act, exp_q.pop_front());
        @(negedge clock);
        reset    = 1'b0;
        exp_pc   = 12'h000;
        prev_opa = 4'h0;
        return;
      end
      #1;
      exp_q.push_back(exp_pack(k, exp_pc, (k >= 5) ? v.inst[3:0] : prev_opa, v));
      check($sformatf("inst=%02h pc=%03h k=%0d", v.inst, exp_pc, k), act, exp_q.pop_front());
      @(negedge clock);
    end
    exp_pc   = exp_pc + 12'h001;
    prev_opa = v.inst[3:0];
  endtask

  // ---------------- test ----------------
  vec_t tbl [12];
  vec_t nop;

  initial begin
    nop    = mk(8'h00, 0, 0, 0, 2'd0, 0, 0);
    tbl[0]  = mk(8'hD5, 0, 0, 1, 2'd2, 0, 0);
    tbl[1]  = mk(8'hB3, 0, 0, 1, 2'd0, 1, 0);
    tbl[2]  = mk(8'hD0, 0, 0, 1, 2'd2, 0, 0);
    tbl[3]  = mk(8'hA3, 0, 0, 1, 2'd0, 0, 0);
    tbl[4]  = mk(8'h83, 0, 0, 1, 2'd1, 0, 0);
    tbl[5]  = mk(8'hF0, 1, 1, 0, 2'd0, 0, 0);
    tbl[6]  = mk(8'hF1, 1, 0, 0, 2'd0, 0, 0);
    tbl[7]  = mk(8'h20, 0, 0, 0, 2'd0, 0, 1);
    tbl[8]  = mk(8'h00, 0, 0, 0, 2'd0, 0, 0);
    tbl[9]  = mk(8'hF2, 0, 0, 0, 2'd0, 0, 1);
    tbl[10] = mk(8'h01, 0, 0, 0, 2'd0, 0, 1);
    tbl[11] = mk(8'h95, 0, 0, 0, 2'd0, 0, 1);

    // Reset view before and after the first reset edge.
    #1;
    check("reset pre-edge", act, RESET_VIEW);
    @(negedge clock);
    check("reset held", act, RESET_VIEW);
    @(negedge clock);
    reset     = 1'b0;
    model_clr = 1'b0;

    // Three NOP cycles: addresses 0,1,2; sync at k=7; no strobes.
    for (int c = 0; c < 3; c++) run_cycle(nop, -1);

    // Table program, then datapath result of D5,B3,D0,A3,83.
    for (int i = 0; i < 12; i++) begin
      run_cycle(tbl[i], -1);
      if (i == 4) begin
        check("acc after program", {14'b0, m_acc}, {14'b0, 4'hA});
        check("r3 after program", {14'b0, m_reg[3]}, {14'b0, 4'h5});
      end
      if (i == 5) check("acc after clb", {14'b0, m_acc}, 18'h0);
    end

    // Walk the PC to 0xFFF, run that cycle, then check the wrap to 0x000.
    while (exp_pc != 12'hFFF) run_cycle(nop, -1);
    run_cycle(nop, -1);
    run_cycle(nop, -1);

    // Load a known accumulator, then abort an LDM in M2.
    run_cycle(mk(8'hD3, 0, 0, 1, 2'd2, 0, 0), -1);
    check("acc before abort", {14'b0, m_acc}, {14'b0, 4'h3});
    run_cycle(mk(8'hD7, 0, 0, 1, 2'd2, 0, 0), 4);
    run_cycle(nop, -1);
    check("acc after abort", {14'b0, m_acc}, {14'b0, 4'h3});
    run_cycle(mk(8'hD9, 0, 0, 1, 2'd2, 0, 0), -1);
    check("acc after reset ldm", {14'b0, m_acc}, {14'b0, 4'h9});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/control_unit.md
# control_unit

Instruction sequencer for the 4-bit CPU. Runs the 8-phase machine cycle on the multiplexed 4-bit bus: drives the 12-bit program counter out in three address nibbles, fetches the 8-bit instruction in two nibbles, and decodes it. It then issues one-clock control strobes to the accumulator/register datapath, whose ports it drives directly.

## Interface
Parameters:
- none. Phase count (8), PC width (12) and opcode map are fixed.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- data_in  in  4  bus read data, sampled in M1 (OPR) and M2 (OPA).
- data_out  out  4  bus write data: PC nibble in A1/A2/A3, else 0.
- data_oe  out  1  high in A1, A2, A3 only.
- sync  out  1  high during X3; marks the start of the next machine cycle.
- clear_carry  out  1  datapath strobe.
- clear_accumulator  out  1  datapath strobe.
- write_accumulator  out  1  datapath strobe.
- acc_input_sel  out  2  accumulator source: 0 = register (ACC_IN_FROM_REG), 1 = ALU (ACC_IN_FROM_ALU), 2 = immediate (inst_operand).
- write_register  out  1  datapath strobe.
- reg_input_sel  out  1  register source: 0 = accumulator (REG_IN_FROM_ACC). Always 0.
- inst_operand  out  4  latched OPA nibble.
- illegal_op  out  1  one-clock pulse in X1 for an undecoded opcode.

## Operation
- 3-bit phase counter, sequence A1→A2→A3→M1→M2→X1→X2→X3→A1, advancing every clock with no stalls.
- PC: 12-bit. Nibbles are output low first: A1 = pc[3:0], A2 = pc[7:4], A3 = pc[11:8].
- pc increments by 1 at the X3→A1 edge, modulo 4096. 0xFFF wraps to 0x000.
- opr latched at the end of M1. opa latched at the end of M2.
- inst_operand = opa. It is stable from X1 through the following M2.
- Strobes are combinational from (phase == X1) and opr/opa. They are 0 in every other phase.
- Decode in X1 (unlisted strobes 0, acc_input_sel 0):
  - 0x00 NOP: no strobe.
  - 0xDn LDM: write_accumulator=1, acc_input_sel=2.
  - 0xAn LD: write_accumulator=1, acc_input_sel=0.
  - 0xBn XCH: write_accumulator=1, acc_input_sel=0, write_register=1. The datapath swaps acc and Rn on one edge.
  - 0x8n ADD: write_accumulator=1, acc_input_sel=1. Carry is not modified.
  - 0xF0 CLB: clear_accumulator=1, clear_carry=1.
  - 0xF1 CLC: clear_carry=1.
  - Anything else: illegal_op=1, no datapath strobe. Execution continues.
- Reset:
  - phase=A1, pc=0, opr=opa=0.
  - All outputs 0, except data_oe=1 and data_out=0 (A1 of address 0).
  - Reset mid-cycle (any phase) aborts the instruction: no X1 strobes for it, and the next phase is A1 with pc=0.

## Timing
- Machine cycle is 8 clocks. First A1 is the clock in which reset is high.
- Once reset deasserts, A1 at address 0 appears on the first clock and the first X1 strobe at clock index 5.
- Datapath effect is visible in the clock after X1 (X2).
- Instruction-to-instruction spacing is exactly 8 clocks.
- sync is high exactly 1 clock in 8, never during reset.
- All state is updated on the posedge only. There are no asynchronous paths except the combinational decode of the registered phase, opr and opa.

## Test plan
- Reset, then run 24 clocks with data_in=0: data_out sequence per cycle is 0,0,0 for pc 0, then 1,0,0 for pc 1, then 2,0,0. sync at clocks 7, 15, 23. No strobes.
- Program D5, B3, D0, A3, 83, one byte per cycle: after cycle 5, datapath acc=0xA and R3=5. Strobes appear only in X1.
- Feed F0 then F1: X1 of cycle 1 has clear_accumulator=1 and clear_carry=1. X1 of cycle 2 has clear_carry=1 only.
- Feed 0x20: illegal_op=1 for one clock in X1, all datapath strobes 0, and the next fetch proceeds at pc+1.
- Force pc to 0xFFF (run 4095 NOP cycles): next A1/A2/A3 nibbles are 0,0,0.
- Assert reset during M2 of an LDM: no write_accumulator that cycle, and the next cycle outputs A1 at pc=0 with data_oe=1.
